// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP frame transmitter: FSM state codes, pattern modes,
// the 75% BT.601 colour-bar table and the black pixel used when an external pixel is missing.
package dvp_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_VSYNC  = 3'd1;
  localparam state_t ST_VBP    = 3'd2;
  localparam state_t ST_ACTIVE = 3'd3;
  localparam state_t ST_VFP    = 3'd4;

  localparam logic [1:0] MODE_RAMP     = 2'd0;
  localparam logic [1:0] MODE_BARS     = 2'd1;
  localparam logic [1:0] MODE_EXT      = 2'd2;
  localparam logic [1:0] MODE_RAMP_ALT = 2'd3;

  localparam logic [7:0] BLACK_Y = 8'h10;
  localparam logic [7:0] BLACK_C = 8'h80;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
  } yuv_t;

  // Bars run white, yellow, cyan, green, magenta, red, blue, black.
  function automatic yuv_t bar_yuv(input logic [2:0] idx);
    case (idx)
      3'd0:    return '{y: 8'hB4, u: 8'h80, v: 8'h80};
      3'd1:    return '{y: 8'hA2, u: 8'h2C, v: 8'h8E};
      3'd2:    return '{y: 8'h83, u: 8'h9C, v: 8'h2C};
      3'd3:    return '{y: 8'h70, u: 8'h48, v: 8'h3A};
      3'd4:    return '{y: 8'h54, u: 8'hB8, v: 8'hC6};
      3'd5:    return '{y: 8'h41, u: 8'h64, v: 8'hD4};
      3'd6:    return '{y: 8'h23, u: 8'hD4, v: 8'h72};
      default: return '{y: BLACK_Y, u: BLACK_C, v: BLACK_C};
    endcase
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational byte source: picks the next DVP byte for a given position in the active
// region from the ramp, the colour bars or the external pixel stream.
module dvp_pattern_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int HW       = 11,
  parameter int VW       = 9
) (
  input  logic          i_active,
  input  logic [HW-1:0] i_byte_idx,
  input  logic [VW-1:0] i_line_idx,
  input  logic [1:0]    i_mode,
  input  logic [15:0]   i_pix_data,
  input  logic          i_pix_valid,
  input  logic [7:0]    i_ext_c,
  output logic [7:0]    o_byte,
  output logic [7:0]    o_ext_c,
  output logic          o_pix_ready,
  output logic          o_miss
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [HW-1:0] w_pix_idx;
  logic [HW-1:0] w_bar_full;
  logic [2:0]    w_bar;
  logic [7:0]    w_ramp;
  yuv_t          w_yuv;

  assign w_pix_idx  = {1'b0, i_byte_idx[HW-1:1]};
  assign w_bar_full = w_pix_idx / HW'(BAR_W);
  assign w_bar      = (w_bar_full > HW'(7)) ? 3'd7 : w_bar_full[2:0];
  assign w_yuv      = bar_yuv(w_bar);
  assign w_ramp     = 8'(i_line_idx) + 8'(i_byte_idx);

  // An external pixel is fetched on the launch of its first (Y) byte; C is held for the second.
  assign o_pix_ready = i_active && (i_mode == MODE_EXT) && !i_byte_idx[0];
  assign o_miss      = o_pix_ready && !i_pix_valid;
  assign o_ext_c     = i_pix_valid ? i_pix_data[7:0] : BLACK_C;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    o_byte = w_ramp;
    case (i_mode)
      MODE_BARS: begin
        case (i_byte_idx[1:0])
          2'd1:    o_byte = w_yuv.u;
          2'd3:    o_byte = w_yuv.v;
          default: o_byte = w_yuv.y;
        endcase
      end
      MODE_EXT: begin
        if (i_byte_idx[0]) o_byte = i_ext_c;
        else               o_byte = i_pix_valid ? i_pix_data[15:8] : BLACK_Y;
      end
      MODE_RAMP, MODE_RAMP_ALT: o_byte = w_ramp;
      default:                  o_byte = w_ramp;
    endcase
  end

endmodule

// File: rtl/dvp_frame_tx.sv
// OV7670-style DVP transmitter: clk/2 pixel clock, frame timing FSM and registered
// vsync/href/data launched on the falling edge of pclk_out.
module dvp_frame_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        pclk_out,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  dout,
  output logic        frame_done,
  output logic        underrun
);

  localparam int LINE    = 2 * H_ACTIVE + H_BLANK;
  localparam int HW      = $clog2(LINE);
  localparam int V_MAX_A = (V_SYNC > V_BP) ? V_SYNC : V_BP;
  localparam int V_MAX_B = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
  localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int VW      = $clog2(V_MAX + 1);

  state_t        r_state;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [1:0]    r_mode;
  logic          r_pclk;
  logic          r_vsync;
  logic          r_href;
  logic [7:0]    r_dout;
  logic [7:0]    r_ext_c;
  logic          r_frame_done;
  logic          r_underrun;

  state_t        w_state_n;
  logic [HW-1:0] w_hcnt_n;
  logic [VW-1:0] w_vcnt_n;
  logic [VW-1:0] w_last_v;
  logic          w_launch;
  logic          w_line_end;
  logic          w_start;
  logic          w_done;
  logic          w_href_n;
  logic [7:0]    w_byte;
  logic [7:0]    w_ext_c;
  logic          w_pix_ready;
  logic          w_miss;

  // The launch edge is the clk on which pclk_out falls; all frame state moves only there.
  assign w_launch   = r_pclk;
  assign w_line_end = (r_hcnt == HW'(LINE - 1));

  always_comb begin
    case (r_state)
      ST_VSYNC:  w_last_v = VW'(V_SYNC - 1);
      ST_VBP:    w_last_v = VW'(V_BP - 1);
      ST_ACTIVE: w_last_v = VW'(V_ACTIVE - 1);
      default:   w_last_v = VW'(V_FP - 1);
    endcase
  end

  // Next position in the frame; outputs are launched for this position, not the current one.
  always_comb begin
    w_state_n = r_state;
    w_hcnt_n  = r_hcnt;
    w_vcnt_n  = r_vcnt;
    w_start   = 1'b0;
    w_done    = 1'b0;
    if (r_state == ST_IDLE) begin
      if (enable) begin
        w_state_n = ST_VSYNC;
        w_start   = 1'b1;
      end
    end else begin
      w_hcnt_n = w_line_end ? '0 : r_hcnt + HW'(1);
      if (w_line_end) begin
        if (r_vcnt == w_last_v) begin
          w_vcnt_n = '0;
          case (r_state)
            ST_VSYNC:  w_state_n = ST_VBP;
            ST_VBP:    w_state_n = ST_ACTIVE;
            ST_ACTIVE: w_state_n = ST_VFP;
            default: begin
              w_done    = 1'b1;
              w_state_n = enable ? ST_VSYNC : ST_IDLE;
              w_start   = enable;
            end
          endcase
        end else begin
          w_vcnt_n = r_vcnt + VW'(1);
        end
      end
    end
  end

  assign w_href_n = (w_state_n == ST_ACTIVE) && (w_hcnt_n < HW'(2 * H_ACTIVE));

  dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .HW       (HW),
    .VW       (VW)
  ) u_pattern (
    .i_active    (w_launch && w_href_n),
    .i_byte_idx  (w_hcnt_n),
    .i_line_idx  (w_vcnt_n),
    .i_mode      (r_mode),
    .i_pix_data  (pix_data),
    .i_pix_valid (pix_valid),
    .i_ext_c     (r_ext_c),
    .o_byte      (w_byte),
    .o_ext_c     (w_ext_c),
    .o_pix_ready (w_pix_ready),
    .o_miss      (w_miss)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pclk       <= 1'b0;
      r_state      <= ST_IDLE;
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_mode       <= MODE_RAMP;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_dout       <= 8'h00;
      r_ext_c      <= BLACK_C;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_pclk       <= ~r_pclk;
      r_frame_done <= 1'b0;
      if (w_launch) begin
        r_state      <= w_state_n;
        r_hcnt       <= w_hcnt_n;
        r_vcnt       <= w_vcnt_n;
        r_vsync      <= (w_state_n == ST_VSYNC);
        r_href       <= w_href_n;
        r_dout       <= w_href_n ? w_byte : 8'h00;
        r_frame_done <= w_done;
        if (w_start)     r_mode  <= mode;
        if (w_pix_ready) r_ext_c <= w_ext_c;
        if (w_start)     r_underrun <= 1'b0;
        else if (w_miss) r_underrun <= 1'b1;
      end
    end
  end

  assign pix_ready  = w_pix_ready;
  assign pclk_out   = r_pclk;
  assign vsync      = r_vsync;
  assign href       = r_href;
  assign dout       = r_dout;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

endmodule
